// File: rtl/scc_bus_initiator.sv
// -----------------------------------------------------------------------------
// scc_bus_initiator
//
// Initiator side of the SCC register/wave-RAM bus. Decodes the SCC window from
// single-cycle CPU access pulses, runs one req/ack transaction per hit, stalls
// the CPU through cpu_wait while the transaction is outstanding, and returns
// read data on cpu_din.
//
// Optional feature macro: SCC_TIMEOUT_EN
//   Defined   : an 8-bit counter aborts a transaction after TIMEOUT
//               clkena-qualified cycles without ack; timeout_err is sticky.
//   Undefined : BUSY waits for ack indefinitely; timeout_err is constant 0.
//
// Parameters:
//   TIMEOUT        cycles to wait for ack before abort (1..255)
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   clkena         SCC-side clock enable; ack only counts when clkena=1
//   cpu_req        one-cycle pulse marking a new CPU access
//   cpu_wr         1=write, 0=read (valid with cpu_req)
//   cpu_addr[15:0] CPU address (valid with cpu_req)
//   cpu_dout[7:0]  CPU write data (valid with cpu_req)
//   scc_en         SCC window currently mapped in
//   scc_plus_mode  0: window 0x98xx, 1: window 0xB8xx
//   cpu_din[7:0]   read data returned to CPU
//   cpu_wait       CPU stall while a transaction is outstanding
//   req            request to SCC slave
//   ack            acknowledge from SCC slave
//   wrt            write qualifier, stable while req=1
//   adr[7:0]       SCC register address, stable while req=1
//   dbo[7:0]       write data to SCC, stable while req=1
//   dbi[7:0]       read data from SCC, valid with ack
//   timeout_err    sticky abort flag
// -----------------------------------------------------------------------------
module scc_bus_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkena,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        scc_en,
    input  logic        scc_plus_mode,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait,
    output logic        req,
    input  logic        ack,
    output logic        wrt,
    output logic [7:0]  adr,
    output logic [7:0]  dbo,
    input  logic [7:0]  dbi,
    output logic        timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        req_r, req_nxt_s;
    logic        wait_r, wait_nxt_s;
    logic        wrt_r, wrt_nxt_s;
    logic [7:0]  adr_r, adr_nxt_s;
    logic [7:0]  dbo_r, dbo_nxt_s;
    logic [7:0]  din_r, din_nxt_s;
    logic [7:0]  win_hi_s;
    logic        hit_s;
    logic        done_s;

`ifdef SCC_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic        terr_r, terr_nxt_s;
`endif

    // Reject out-of-range configurations at elaboration time.
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("scc_bus_initiator: TIMEOUT must be in 1..255");
    end

    // Window decode: SCC+ mode moves the window from 0x98xx to 0xB8xx.
    always_comb begin
        win_hi_s = scc_plus_mode ? 8'hB8 : 8'h98;
        hit_s    = scc_en && (cpu_addr[15:8] == win_hi_s);
        done_s   = clkena && ack;
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = req_r;
        wait_nxt_s  = wait_r;
        wrt_nxt_s   = wrt_r;
        adr_nxt_s   = adr_r;
        dbo_nxt_s   = dbo_r;
        din_nxt_s   = din_r;
`ifdef SCC_TIMEOUT_EN
        cnt_nxt_s   = cnt_r;
        terr_nxt_s  = terr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cpu_req && hit_s) begin
                    state_nxt_s = ST_BUSY;
                    req_nxt_s   = 1'b1;
                    wait_nxt_s  = 1'b1;
                    wrt_nxt_s   = cpu_wr;
                    adr_nxt_s   = cpu_addr[7:0];
                    dbo_nxt_s   = cpu_dout;
`ifdef SCC_TIMEOUT_EN
                    cnt_nxt_s   = 8'h00;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // ack wins over a timeout expiring on the same cycle.
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                    req_nxt_s   = 1'b0;
                    wait_nxt_s  = 1'b0;
                    if (!wrt_r) begin
                        din_nxt_s = dbi;
                    end else begin
                        din_nxt_s = din_r;
                    end
                end
`ifdef SCC_TIMEOUT_EN
                else if (cnt_r == TIMEOUT_C) begin
                    state_nxt_s = ST_IDLE;
                    req_nxt_s   = 1'b0;
                    wait_nxt_s  = 1'b0;
                    din_nxt_s   = 8'hFF;
                    terr_nxt_s  = 1'b1;
                end else if (clkena) begin
                    cnt_nxt_s   = cnt_r + 8'h01;
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
`else
                else begin
                    state_nxt_s = ST_BUSY;
                end
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
                req_nxt_s   = 1'b0;
                wait_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            wait_r  <= 1'b0;
            wrt_r   <= 1'b0;
            adr_r   <= 8'h00;
            dbo_r   <= 8'h00;
            din_r   <= 8'hFF;
`ifdef SCC_TIMEOUT_EN
            cnt_r   <= 8'h00;
            terr_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            req_r   <= req_nxt_s;
            wait_r  <= wait_nxt_s;
            wrt_r   <= wrt_nxt_s;
            adr_r   <= adr_nxt_s;
            dbo_r   <= dbo_nxt_s;
            din_r   <= din_nxt_s;
`ifdef SCC_TIMEOUT_EN
            cnt_r   <= cnt_nxt_s;
            terr_r  <= terr_nxt_s;
`endif
        end
    end

    assign req      = req_r;
    assign cpu_wait = wait_r;
    assign wrt      = wrt_r;
    assign adr      = adr_r;
    assign dbo      = dbo_r;
    assign cpu_din  = din_r;
`ifdef SCC_TIMEOUT_EN
    assign timeout_err = terr_r;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_scc_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_scc_bus_initiator
//
// Directed self-checking bench for scc_bus_initiator. Inputs are driven and
// outputs sampled 1 ns after each rising clock edge; "cycle k" below means the
// interval following the k-th rising edge of a scenario.
// -----------------------------------------------------------------------------
module tb_scc_bus_initiator;

`ifdef SCC_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clkena = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        scc_en = 1'b0;
    logic        scc_plus_mode = 1'b0;
    logic [7:0]  cpu_din;
    logic        cpu_wait;
    logic        req;
    logic        ack = 1'b0;
    logic        wrt;
    logic [7:0]  adr;
    logic [7:0]  dbo;
    logic [7:0]  dbi = 8'h00;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    scc_bus_initiator #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clkena(clkena),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .scc_en(scc_en), .scc_plus_mode(scc_plus_mode),
        .cpu_din(cpu_din), .cpu_wait(cpu_wait), .req(req), .ack(ack),
        .wrt(wrt), .adr(adr), .dbo(dbo), .dbi(dbi), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if ({req, cpu_wait, wrt} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: req/wait/wrt=%b expected 000", {req, cpu_wait, wrt}); end
        n_checks++; if ({adr, dbo} !== 16'h0000) begin n_fail++; $display("FAIL reset_adr_dbo: got %h expected 0000", {adr, dbo}); end
        n_checks++; if (cpu_din !== 8'hFF) begin n_fail++; $display("FAIL reset_din: got %h expected ff", cpu_din); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
    endtask

    task automatic test_reset_mid_busy();
        scc_en = 1'b1; scc_plus_mode = 1'b0; clkena = 1'b1; ack = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h9801; cpu_dout = 8'h12;
        tick();
        cpu_req = 1'b0;
        n_checks++; if ({req, cpu_wait} !== 2'b11) begin n_fail++; $display("FAIL rmb_started: req/wait=%b expected 11", {req, cpu_wait}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({req, cpu_wait, cpu_din} !== {2'b00, 8'hFF}) begin n_fail++; $display("FAIL rmb_reset: req/wait/din=%b/%h expected 00/ff", {req, cpu_wait}, cpu_din); end
        ack = 1'b1; dbi = 8'hA5;
        tick(); tick();
        ack = 1'b0;
        n_checks++; if ({req, cpu_wait, cpu_din} !== {2'b00, 8'hFF}) begin n_fail++; $display("FAIL rmb_late_ack: req/wait/din=%b/%h expected 00/ff", {req, cpu_wait}, cpu_din); end
    endtask

    task automatic test_write_hit();
        scc_en = 1'b1; scc_plus_mode = 1'b0; clkena = 1'b1; ack = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h9885; cpu_dout = 8'h5A;
        tick();
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_dout = 8'h00; cpu_addr = 16'h0000;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) ack = 1'b1;
            n_checks++; if ({req, cpu_wait, wrt, adr, dbo} !== {3'b111, 8'h85, 8'h5A}) begin n_fail++; $display("FAIL wr_hold c%0d: req/wait/wrt=%b adr=%h dbo=%h expected 111 85 5a", c, {req, cpu_wait, wrt}, adr, dbo); end
            tick();
        end
        ack = 1'b0;
        n_checks++; if ({req, cpu_wait} !== 2'b00) begin n_fail++; $display("FAIL wr_done: req/wait=%b expected 00", {req, cpu_wait}); end
        n_checks++; if (cpu_din !== 8'hFF) begin n_fail++; $display("FAIL wr_din: got %h expected ff", cpu_din); end
    endtask

    task automatic test_read_plus();
        scc_en = 1'b1; scc_plus_mode = 1'b1; clkena = 1'b1; ack = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'hB8AA; cpu_dout = 8'h77;
        tick();
        cpu_req = 1'b0;
        n_checks++; if ({req, wrt, adr} !== {2'b10, 8'hAA}) begin n_fail++; $display("FAIL rd_start: req/wrt=%b adr=%h expected 10 aa", {req, wrt}, adr); end
        ack = 1'b1; dbi = 8'h3C; clkena = 1'b0;
        tick();
        n_checks++; if ({req, cpu_wait, cpu_din} !== {2'b11, 8'hFF}) begin n_fail++; $display("FAIL rd_gated: req/wait/din=%b/%h expected 11/ff", {req, cpu_wait}, cpu_din); end
        clkena = 1'b1;
        tick();
        ack = 1'b0; dbi = 8'h00;
        n_checks++; if ({req, cpu_wait, cpu_din} !== {2'b00, 8'h3C}) begin n_fail++; $display("FAIL rd_done: req/wait/din=%b/%h expected 00/3c", {req, cpu_wait}, cpu_din); end
    endtask

    task automatic test_miss();
        scc_en = 1'b1; scc_plus_mode = 1'b1; clkena = 1'b1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h9885;
        tick();
        cpu_req = 1'b0;
        n_checks++; if ({req, cpu_wait, cpu_din} !== {2'b00, 8'h3C}) begin n_fail++; $display("FAIL miss_mode: req/wait/din=%b/%h expected 00/3c", {req, cpu_wait}, cpu_din); end
        scc_en = 1'b0; scc_plus_mode = 1'b0;
        cpu_req = 1'b1; cpu_addr = 16'h9885;
        tick();
        cpu_req = 1'b0;
        n_checks++; if ({req, cpu_wait, cpu_din} !== {2'b00, 8'h3C}) begin n_fail++; $display("FAIL miss_en: req/wait/din=%b/%h expected 00/3c", {req, cpu_wait}, cpu_din); end
        ack = 1'b1; dbi = 8'h99;
        tick();
        ack = 1'b0;
        n_checks++; if ({req, cpu_wait, cpu_din} !== {2'b00, 8'h3C}) begin n_fail++; $display("FAIL stray_ack: req/wait/din=%b/%h expected 00/3c", {req, cpu_wait}, cpu_din); end
    endtask

    task automatic test_back_to_back();
        scc_en = 1'b1; scc_plus_mode = 1'b0; clkena = 1'b1; ack = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h9810; cpu_dout = 8'h11;
        tick();
        // Stray access while BUSY must be dropped.
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h9811; cpu_dout = 8'h99;
        tick();
        cpu_req = 1'b0;
        n_checks++; if ({req, wrt, adr, dbo} !== {2'b11, 8'h10, 8'h11}) begin n_fail++; $display("FAIL busy_drop: req/wrt=%b adr=%h dbo=%h expected 11 10 11", {req, wrt}, adr, dbo); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_checks++; if ({req, cpu_wait} !== 2'b00) begin n_fail++; $display("FAIL b2b_gap: req/wait=%b expected 00", {req, cpu_wait}); end
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h9822; cpu_dout = 8'h33;
        tick();
        cpu_req = 1'b0;
        n_checks++; if ({req, cpu_wait, wrt, adr, dbo} !== {3'b110, 8'h22, 8'h33}) begin n_fail++; $display("FAIL b2b_second: req/wait/wrt=%b adr=%h dbo=%h expected 110 22 33", {req, cpu_wait, wrt}, adr, dbo); end
        ack = 1'b1; dbi = 8'hC5;
        tick();
        ack = 1'b0;
        n_checks++; if ({req, cpu_wait, cpu_din} !== {2'b00, 8'hC5}) begin n_fail++; $display("FAIL min_latency: req/wait/din=%b/%h expected 00/c5", {req, cpu_wait}, cpu_din); end
    endtask

`ifdef SCC_TIMEOUT_EN
    task automatic test_timeout();
        scc_en = 1'b1; scc_plus_mode = 1'b0; clkena = 1'b1; ack = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h9801;
        tick();
        cpu_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            n_checks++; if ({req, cpu_wait} !== 2'b11) begin n_fail++; $display("FAIL to_wait c%0d: req/wait=%b expected 11", c, {req, cpu_wait}); end
            tick();
        end
        n_checks++; if ({req, cpu_wait, cpu_din, timeout_err} !== {2'b00, 8'hFF, 1'b1}) begin n_fail++; $display("FAIL to_abort: req/wait=%b din=%h terr=%b expected 00 ff 1", {req, cpu_wait}, cpu_din, timeout_err); end
        ack = 1'b1;
        tick(); tick();
        ack = 1'b0;
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b expected 0", timeout_err); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_reset_mid_busy();
        test_write_hit();
        test_read_plus();
        test_miss();
        test_back_to_back();
`ifdef SCC_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
